adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead `adder` instance between `N_REQ` requesters. Each requester presents operands over a valid/ready handshake. The block grants one request per cycle, drives the shared adder, and returns the sum, carry and winning requester ID through a registered response port. It sits between the ALU front-end clients and the single adder datapath.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand width, fixed to the `adder` width.
- `ID_W`, `$clog2(N_REQ)`: requester ID width (localparam).

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `req_a` in `N_REQ*WIDTH`: operand A, requester i in slice `[i*WIDTH +: WIDTH]`.
- `req_b` in `N_REQ*WIDTH`: operand B, same packing as `req_a`.
- `req_sub` in `N_REQ`: subtract select, only present with `ADDER_ARB_SUB_EN`.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: index of the requester that produced the result.
- `rsp_sum` out `WIDTH`: `a+b` (or `a-b`), modulo 2^WIDTH.
- `rsp_carry` out 1: adder carry-out (for subtract: 1 means no borrow).

## Operation
- Response register states:
  - EMPTY: `rsp_valid=0`.
  - FULL: `rsp_valid=1`.
- `can_accept = !rsp_valid || rsp_ready`.
- Grant:
  - When `can_accept` is true, at most one `req_ready` bit is asserted: the first `req_valid` bit at or after `ptr`, searching upward with wrap at `N_REQ-1 -> 0`.
  - When `can_accept` is false, `req_ready` is all zero.
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`.
- Accept:
  - The granted operands are muxed into the shared adder with `c0=0`.
  - Sum, carry and ID are captured into the response register; state goes to FULL.
  - `ptr` updates to `(grant_idx+1) mod N_REQ`.
- With no grant, `ptr` is held.
- Drain: `rsp_valid && rsp_ready` with no new grant returns the register to EMPTY.
- Drain and accept in the same cycle: the register reloads and stays FULL, so there is no bubble.
- Response fields are stable while `rsp_valid && !rsp_ready`.
- Requesters may drop `req_valid` at any time; a request is not committed until it is granted.
- Width rule: sum is truncated to `WIDTH` bits; carry is bit `WIDTH` of the full result.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_carry=0`.
  - `ptr=0`.
  - `req_ready=0` until the first cycle after `rst_n` deasserts.
- Latency: 1 cycle from the handshake edge to `rsp_valid`.
- Throughput: 1 result per cycle while `rsp_ready=1`.
- Adder path: combinational in the grant cycle, registered at the edge.
- Reset asserted mid-operation: the pending response is discarded immediately and asynchronously, and `ptr` returns to 0.
- Fairness: with all requesters continuously valid and `rsp_ready=1`, grants rotate 0,1,..,N_REQ-1,0.
- Any waiting requester is granted within `N_REQ` accept cycles.

## Configuration
- `ADDER_ARB_SUB_EN` defined:
  - The `req_sub` port exists.
  - A granted request with `req_sub=1` drives B as `~b` and sets `c0=1`, giving `rsp_sum=a-b` and `rsp_carry=(a>=b)` unsigned.
- Not defined:
  - No `req_sub` port.
  - The adder always runs with `c0=0` and the B operand unmodified.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_WIDTH=32`.
  - The `adder_rsp_t` struct (`id`, `sum`, `carry`).
  - A helper function for the next round-robin pointer.
- Sub-module `rr_arbiter` is natural:
  - Parameterised by `N_REQ`.
  - Inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `gnt_idx`.
  - Purely combinational.
  - The pointer register stays in `adder_arbiter`.
- The datapath instantiates the existing `adder` once; the block contains no other arithmetic.

## Test plan
- Reset, then only requester 2 valid with `a=32'h0000_0005`, `b=32'h0000_0007` -> `rsp_valid` next cycle, `rsp_id=2`, `rsp_sum=12`, `rsp_carry=0`.
- Requester 0 with `a=32'hFFFF_FFFF`, `b=1` -> `rsp_sum=0`, `rsp_carry=1` (wrap-around).
- All four requesters valid, `rsp_ready=1` for 8 cycles -> `rsp_id` sequence 0,1,2,3,0,1,2,3.
  - One result per cycle, no bubbles.
- `rsp_ready=0` for 3 cycles with all requesters valid -> `req_ready=0` throughout and response fields held stable.
  - On release, the next grant goes to `ptr` (round-robin preserved).
- `rst_n` pulsed low while `rsp_valid=1` -> `rsp_valid` drops immediately without waiting for a clock edge.
  - After reset, the first grant with all requesters valid goes to requester 0.
- With `ADDER_ARB_SUB_EN`: `a=3`, `b=5`, `sub=1` -> `rsp_sum=32'hFFFF_FFFE`, `rsp_carry=0`.
  - `a=5`, `b=3`, `sub=1` -> `rsp_sum=2`, `rsp_carry=1`.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the ALU adder datapath and its arbiter.
//   ALU_WIDTH     : operand width of the shared adder
//   ALU_ID_MAX_W  : widest requester ID the response struct can hold (8 reqs)
//   rsp_state_t   : occupancy of the registered response port
//   adder_rsp_t   : one adder result tagged with the producing requester
//   rr_next_ptr() : round-robin pointer that follows a given grant index
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH    = 32;
   localparam int ALU_ID_MAX_W = 3;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   typedef struct packed {
      logic [ALU_ID_MAX_W-1:0] id;
      logic [ALU_WIDTH-1:0]    sum;
      logic                    carry;
   } adder_rsp_t;

   // Priority moves to the requester just above the winner, wrapping at n-1.
   function automatic int unsigned rr_next_ptr(input int unsigned idx,
                                               input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder
// 32-bit carry-lookahead adder built from 4-bit lookahead groups.
//   a, b  : operands
//   c0    : carry-in
//   sum   : a + b + c0 modulo 2^32
//   carry : carry-out of the top bit
// ---------------------------------------------------------------------------
module adder
   import alu_pkg::*;
(
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   input  logic                 c0,
   output logic [ALU_WIDTH-1:0] sum,
   output logic                 carry
);

   logic [ALU_WIDTH-1:0] w_p;
   logic [ALU_WIDTH-1:0] w_g;
   logic [ALU_WIDTH:0]   w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Each 4-bit group derives its internal carries and its carry-out directly
   // from the group carry-in, so only the group carries chain.
   always_comb begin
      w_c    = '0;
      w_c[0] = c0;
      for (int k = 0; k < ALU_WIDTH / 4; k++) begin
         w_c[4*k+1] = w_g[4*k]
                    | (w_p[4*k] & w_c[4*k]);
         w_c[4*k+2] = w_g[4*k+1]
                    | (w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
         w_c[4*k+3] = w_g[4*k+2]
                    | (w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
         w_c[4*k+4] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      end
   end

   assign sum   = w_p ^ w_c[ALU_WIDTH-1:0];
   assign carry = w_c[ALU_WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant selection.
//   req     : per-requester request bits
//   ptr     : requester with highest priority this cycle
//   en      : when low, nothing is granted
//   gnt     : one-hot grant (all zero when en is low or no request)
//   gnt_idx : index of the granted requester (0 when nothing granted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_idx
);

   logic w_found;

   // First pass looks from ptr upward; the second pass covers the wrap from
   // 0 back up to ptr and only matters when the first found nothing.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      if (en) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (i >= int'(ptr))) begin
               w_found = 1'b1;
               gnt_idx = ID_W'(i);
            end
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i]) begin
               w_found = 1'b1;
               gnt_idx = ID_W'(i);
            end
         end
         if (w_found) begin
            gnt[gnt_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
// Shares one carry-lookahead adder between N_REQ requesters. One request is
// granted per cycle in round-robin order and its result is returned through
// a single registered response slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake, req_ready is one-hot
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub             : subtract select (only with ADDER_ARB_SUB_EN)
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester that produced the result
//   rsp_sum, rsp_carry  : adder sum and carry-out (carry=1 means no borrow)
// Optional feature macro: ADDER_ARB_SUB_EN enables per-request subtraction.
// ---------------------------------------------------------------------------
module adder_arbiter
   import alu_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int WIDTH = ALU_WIDTH,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
`ifdef ADDER_ARB_SUB_EN
   input  logic [N_REQ-1:0]   req_sub,
`endif
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [WIDTH-1:0]   rsp_sum,
   output logic               rsp_carry
);

   rsp_state_t       r_state;
   rsp_state_t       w_state_next;
   adder_rsp_t       r_rsp;
   logic [ID_W-1:0]  r_ptr;
   logic             r_run;
   logic             w_can_accept;
   logic             w_accept;
   logic [N_REQ-1:0] w_gnt;
   logic [ID_W-1:0]  w_gnt_idx;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_adder_b;
   logic             w_c0;
   logic [WIDTH-1:0] w_sum;
   logic             w_carry;
   logic             w_unused_id_bits;

   // The slot can take a new result when it is empty or being drained now.
   // r_run keeps grants off until the first edge after reset is released.
   assign w_can_accept = (r_state == RSP_EMPTY) || rsp_ready;
   assign w_accept     = |w_gnt;
   assign req_ready    = w_gnt;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
      .req     (req_valid),
      .ptr     (r_ptr),
      .en      (r_run && w_can_accept),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   // One-hot AND-OR mux of the winning operands into the shared adder.
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_op_a = w_op_a | req_a[i*WIDTH +: WIDTH];
            w_op_b = w_op_b | req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Subtraction is a + ~b + 1, so the carry-out reads as "no borrow".
`ifdef ADDER_ARB_SUB_EN
   assign w_c0      = |(w_gnt & req_sub);
   assign w_adder_b = w_c0 ? ~w_op_b : w_op_b;
`else
   assign w_c0      = 1'b0;
   assign w_adder_b = w_op_b;
`endif

   adder u_adder (
      .a     (w_op_a),
      .b     (w_adder_b),
      .c0    (w_c0),
      .sum   (w_sum),
      .carry (w_carry)
   );

   // Response slot occupancy: a new accept always wins over a drain so that
   // back-to-back results leave no empty cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RSP_EMPTY: begin
            if (w_accept) w_state_next = RSP_FULL;
         end
         RSP_FULL: begin
            if (w_accept)       w_state_next = RSP_FULL;
            else if (rsp_ready) w_state_next = RSP_EMPTY;
         end
      endcase
   end

   // State, pointer and response payload; the payload only changes on an
   // accept, which keeps it stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RSP_EMPTY;
         r_ptr   <= '0;
         r_run   <= 1'b0;
         r_rsp   <= '0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
         if (w_accept) begin
            r_ptr <= ID_W'(rr_next_ptr(32'(w_gnt_idx), N_REQ));
            r_rsp <= '{id: ALU_ID_MAX_W'(w_gnt_idx), sum: w_sum, carry: w_carry};
         end
      end
   end

   assign rsp_valid        = (r_state == RSP_FULL);
   assign rsp_id           = r_rsp.id[ID_W-1:0];
   assign rsp_sum          = r_rsp.sum;
   assign rsp_carry        = r_rsp.carry;
   assign w_unused_id_bits = ^r_rsp.id;

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
// Directed bench for adder_arbiter (N_REQ=4). Stimulus pushes hand-computed
// expected responses into a queue; a monitor pops one per response handshake.
// Define ADDER_ARB_SUB_EN to also exercise subtraction.
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] sum;
      logic        carry;
   } expRsp_t;

   logic         clk = 1'b0;
   logic         rstN;
   logic [3:0]   reqValid;
   logic [3:0]   reqReady;
   logic [127:0] reqA;
   logic [127:0] reqB;
`ifdef ADDER_ARB_SUB_EN
   logic [3:0]   reqSub;
`endif
   logic         rspValid;
   logic         rspReady;
   logic [1:0]   rspId;
   logic [31:0]  rspSum;
   logic         rspCarry;

   expRsp_t expQ[$];
   expRsp_t monExp;
   int      errors = 0;
   int      checks = 0;

   logic [31:0] fairA     [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h8000_0000};
   logic [31:0] fairB     [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h8000_0000};
   logic [31:0] fairSum   [4] = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0000};
   logic        fairCarry [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [3:0]  expGnt;

   always #5 clk = ~clk;

   adder_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_a     (reqA),
      .req_b     (reqB),
`ifdef ADDER_ARB_SUB_EN
      .req_sub   (reqSub),
`endif
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_id    (rspId),
      .rsp_sum   (rspSum),
      .rsp_carry (rspCarry)
   );

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] a,
                                input logic [31:0] b);
      reqA[idx*32 +: 32] = a;
      reqB[idx*32 +: 32] = b;
   endtask

   task automatic pushExp(input logic [1:0] id, input logic [31:0] sum,
                          input logic carry);
      expQ.push_back({id, sum, carry});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor: a response transfers at the next rising edge whenever valid and
   // ready are both high at the falling edge.
   always @(negedge clk) begin
      if (rspValid && rspReady) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected response: got id %0d sum 0x%0h, expected none",
                     rspId, rspSum);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rsp_id", 64'(rspId), 64'(monExp.id));
            checkOutput("rsp_sum", 64'(rspSum), 64'(monExp.sum));
            checkOutput("rsp_carry", 64'(rspCarry), 64'(monExp.carry));
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: time limit reached before end of test");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN     = 1'b0;
      reqValid = 4'hF;
      reqA     = '0;
      reqB     = '0;
      rspReady = 1'b1;
`ifdef ADDER_ARB_SUB_EN
      reqSub   = 4'h0;
`endif
      repeat (2) tick();

      // Reset values, with every requester asking.
      checkOutput("reset rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("reset rsp_id", 64'(rspId), 64'd0);
      checkOutput("reset rsp_sum", 64'(rspSum), 64'd0);
      checkOutput("reset rsp_carry", 64'(rspCarry), 64'd0);
      checkOutput("reset req_ready", 64'(reqReady), 64'd0);

      rstN = 1'b1;
      #1 checkOutput("req_ready before first edge", 64'(reqReady), 64'd0);
      tick();

      // Only requester 2: 5 + 7.
      reqValid = 4'b0100;
      applyStimulus(2, 32'h0000_0005, 32'h0000_0007);
      #1 checkOutput("grant req2", 64'(reqReady), 64'h4);
      pushExp(2'd2, 32'd12, 1'b0);
      tick();
      reqValid = 4'b0000;
      checkOutput("one-cycle latency rsp_valid", 64'(rspValid), 64'd1);
      tick();

      // Requester 0 wrap-around: ptr is 3, search wraps to 0.
      reqValid = 4'b0001;
      applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001);
      #1 checkOutput("grant req0 wrap", 64'(reqReady), 64'h1);
      pushExp(2'd0, 32'h0000_0000, 1'b1);
      tick();

      // Requester 3 alone brings ptr back to 0.
      reqValid = 4'b1000;
      applyStimulus(3, 32'h1234_5678, 32'h1111_1111);
      #1 checkOutput("grant req3", 64'(reqReady), 64'h8);
      pushExp(2'd3, 32'h2345_6789, 1'b0);
      tick();

      // Fairness: all valid, eight back-to-back grants.
      for (int i = 0; i < 4; i++) applyStimulus(i, fairA[i], fairB[i]);
      reqValid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         expGnt = 4'b0001 << (k % 4);
         #1 checkOutput("round-robin grant", 64'(reqReady), 64'(expGnt));
         pushExp(2'(k % 4), fairSum[k % 4], fairCarry[k % 4]);
         @(posedge clk);
         #1 checkOutput("no bubble rsp_valid", 64'(rspValid), 64'd1);
         #1;
      end

      // Consumer stall: nothing granted, response held.
      rspReady = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1 checkOutput("stall req_ready", 64'(reqReady), 64'd0);
         checkOutput("stall rsp_valid", 64'(rspValid), 64'd1);
         checkOutput("stall rsp_id", 64'(rspId), 64'd3);
         checkOutput("stall rsp_sum", 64'(rspSum), 64'h0);
         checkOutput("stall rsp_carry", 64'(rspCarry), 64'd1);
         tick();
      end
      rspReady = 1'b1;
      #1 checkOutput("grant after stall", 64'(reqReady), 64'h1);
      pushExp(2'd0, 32'h0000_0101, 1'b0);
      tick();
      reqValid = 4'b0000;
      tick();

      // Asynchronous reset while a response is pending (ptr is 1 here).
      rspReady = 1'b0;
      reqValid = 4'b0010;
      #1 checkOutput("grant req1 before reset", 64'(reqReady), 64'h2);
      tick();
      reqValid = 4'b0000;
      checkOutput("pending before reset", 64'(rspValid), 64'd1);
      #2 rstN = 1'b0;
      #1 checkOutput("async reset rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("async reset rsp_sum", 64'(rspSum), 64'd0);
      tick();
      tick();
      rstN = 1'b1;
      tick();
      reqValid = 4'hF;
      rspReady = 1'b1;
      #1 checkOutput("first grant after reset", 64'(reqReady), 64'h1);
      pushExp(2'd0, 32'h0000_0101, 1'b0);
      tick();
      reqValid = 4'b0000;

`ifdef ADDER_ARB_SUB_EN
      tick();
      reqValid = 4'b0001;
      reqSub   = 4'b0001;
      applyStimulus(0, 32'd3, 32'd5);
      pushExp(2'd0, 32'hFFFF_FFFE, 1'b0);
      tick();
      applyStimulus(0, 32'd5, 32'd3);
      pushExp(2'd0, 32'h0000_0002, 1'b1);
      tick();
      reqValid = 4'b0000;
      reqSub   = 4'b0000;
`endif

      repeat (3) tick();
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
